// File: rtl/srq_flag_bank.sv
// srq_flag_bank
//   A bank of CH set/reset flags with a lowest-index priority arbiter. The
//   arbiter raises one interrupt request toward the processor. It holds that
//   request until the processor acknowledges it.
//
//   Each flag follows the priority order below:
//     set&clr -> SET_PRIORITY, set -> 1, clr -> 0, ack-clear -> 0, else hold.
//
//   Ports:
//     clk     system clock, all state updates on posedge
//     reset   synchronous, active-high reset
//     set     [CH]    per-channel set request
//     clr     [CH]    per-channel clear request
//     mask    [CH]    1 = channel may raise irq (flags capture regardless)
//     ack     processor acknowledge of the current irq
//     q       [CH]    flag state (registered)
//     irq     request to processor (registered, high exactly while in REQ)
//     irq_id  [IDX_W] index of the channel being requested (registered)
//
//   Optional feature macro: SRQ_EDGE_DETECT_EN
//     When defined, set is rising-edge sensitive. A held-high set raises its
//     flag only once. When undefined, set is level-sensitive.
module srq_flag_bank #(
    parameter int CH           = 8,
    parameter int IDX_W        = 3,
    parameter int SET_PRIORITY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH-1:0]    set,
    input  logic [CH-1:0]    clr,
    input  logic [CH-1:0]    mask,
    input  logic             ack,
    output logic [CH-1:0]    q,
    output logic             irq,
    output logic [IDX_W-1:0] irq_id
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CH-1:0]     set_eff;
    logic [CH-1:0]     ack_clr;
    logic [CH-1:0]     q_nxt;
    logic [CH-1:0]     pend;
    logic              pend_any;
    logic [IDX_W-1:0]  pend_idx;

`ifdef SRQ_EDGE_DETECT_EN
    logic [CH-1:0] set_d;

    always_ff @(posedge clk) begin
        if (reset) set_d <= '0;
        else       set_d <= set;
    end

    assign set_eff = set & ~set_d;
`else
    assign set_eff = set;
`endif

    // An ack applies only in REQ, and only to the latched channel. In IDLE
    // the ack is dropped. That gives exactly one clear per REQ entry.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < CH; i++) begin
            ack_clr[i] = (state == REQ) && ack && (irq_id == IDX_W'(i));
        end
    end

    always_comb begin
        q_nxt = q;
        for (int i = 0; i < CH; i++) begin
            if (set_eff[i] && clr[i]) q_nxt[i] = (SET_PRIORITY != 0);
            else if (set_eff[i])      q_nxt[i] = 1'b1;
            else if (clr[i])          q_nxt[i] = 1'b0;
            else if (ack_clr[i])      q_nxt[i] = 1'b0;
        end
    end

    // Lowest-index priority encode. The loop scans downward, so the lowest
    // pending channel is written last and wins.
    assign pend     = q & mask;
    assign pend_any = |pend;

    always_comb begin
        pend_idx = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (pend[i]) pend_idx = IDX_W'(i);
        end
    end

    // State register plus the flags and latched index
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            q      <= '0;
            irq_id <= '0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            if (state == IDLE && pend_any) irq_id <= pend_idx;
        end
    end

    // Next-state logic. Once in REQ, only ack leaves; clr and mask are ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pend_any) state_nxt = REQ;
            REQ:     if (ack)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. irq is decoded from the state flop, so it is registered.
    always_comb begin
        irq = (state == REQ);
    end

endmodule

// File: tb/tb_srq_flag_bank.sv
module tb_srq_flag_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] set, clr, mask;
    logic       ack;
    logic [7:0] q0, q1;
    logic       irq0, irq1;
    logic [2:0] id0, id1;

    always #5 clk = ~clk;

    srq_flag_bank #(.CH(8), .IDX_W(3), .SET_PRIORITY(1)) dut0 (
        .clk(clk), .reset(reset), .set(set), .clr(clr), .mask(mask), .ack(ack),
        .q(q0), .irq(irq0), .irq_id(id0)
    );

    srq_flag_bank #(.CH(8), .IDX_W(3), .SET_PRIORITY(0)) dut1 (
        .clk(clk), .reset(reset), .set(set), .clr(clr), .mask(mask), .ack(ack),
        .q(q1), .irq(irq1), .irq_id(id1)
    );

    typedef struct packed {
        logic [7:0] q0;
        logic       irq0;
        logic [2:0] id0;
        logic [7:0] q1;
        logic       irq1;
        logic [2:0] id1;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [7:0] mq0 = '0, mq1 = '0, mset_d = '0;
    bit         mreq0 = 0, mreq1 = 0;
    logic [2:0] mid0 = '0, mid1 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit prio, input logic [7:0] seff,
                              inout logic [7:0] mq, inout bit mreq, inout logic [2:0] mid);
        logic [7:0] nq;
        bit         nreq;
        logic [2:0] nid;
        nq = mq; nreq = mreq; nid = mid;
        for (int i = 0; i < 8; i++) begin
            if (seff[i] && clr[i])                   nq[i] = prio;
            else if (seff[i])                        nq[i] = 1'b1;
            else if (clr[i])                         nq[i] = 1'b0;
            else if (mreq && ack && mid == 3'(i))    nq[i] = 1'b0;
        end
        if (!mreq) begin
            if ((mq & mask) != 8'h00) begin
                nreq = 1;
                for (int i = 7; i >= 0; i--) if (mq[i] && mask[i]) nid = 3'(i);
            end
        end else if (ack) begin
            nreq = 0;
        end
        if (reset) begin
            nq = '0; nreq = 0; nid = '0;
        end
        mq = nq; mreq = nreq; mid = nid;
    endtask

    // One clock: predict, push, clock, then pop and compare.
    task automatic step();
        logic [7:0] seff;
        exp_t e;
`ifdef SRQ_EDGE_DETECT_EN
        seff = set & ~mset_d;
`else
        seff = set;
`endif
        model_step(1'b1, seff, mq0, mreq0, mid0);
        model_step(1'b0, seff, mq1, mreq1, mid1);
        mset_d = reset ? 8'h00 : set;
        sb.push_back('{q0: mq0, irq0: mreq0, id0: mid0, q1: mq1, irq1: mreq1, id1: mid1});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("q0",   32'(q0),   32'(e.q0));
        chk("irq0", 32'(irq0), 32'(e.irq0));
        chk("id0",  32'(id0),  32'(e.id0));
        chk("q1",   32'(q1),   32'(e.q1));
        chk("irq1", 32'(irq1), 32'(e.irq1));
        chk("id1",  32'(id1),  32'(e.id1));
    endtask

    task automatic cleanup();
        set = 8'h00; clr = 8'hFF; mask = 8'h00; ack = 1'b1;
        step(); step();
        clr = 8'h00; ack = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; set = 8'hFF; clr = 8'h00; mask = 8'h00; ack = 1'b0;
        #1;
        // reset with set asserted
        step(); step();
        chk("rst_q", 32'(q0), 32'h0);
        chk("rst_irq", 32'(irq0), 32'h0);
        chk("rst_id", 32'(id0), 32'h0);
        reset = 1'b0; set = 8'h00;
        step();

        // two pending channels served lowest first
        mask = 8'hFF; set = 8'h24;
        step();
        chk("t2_q", 32'(q0), 32'h24);
        set = 8'h00;
        step();
        chk("t2_irq", 32'(irq0), 32'h1);
        chk("t2_id", 32'(id0), 32'h2);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t2_q_ack", 32'(q0), 32'h20);
        chk("t2_irq_gap", 32'(irq0), 32'h0);
        step();
        chk("t2_id5", 32'(id0), 32'h5);
        chk("t2_irq5", 32'(irq0), 32'h1);
        cleanup();

        // set/clear collision under both priorities
        set = 8'h08; clr = 8'h08;
        step();
        set = 8'h00; clr = 8'h00;
        chk("t3_prio1", 32'(q0[3]), 32'h1);
        chk("t3_prio0", 32'(q1[3]), 32'h0);
        step();
        cleanup();

        // masked flag captures but does not request
        mask = 8'h00; set = 8'h01;
        step();
        set = 8'h00;
        step(); step();
        chk("t4_q", 32'(q0), 32'h01);
        chk("t4_irq_masked", 32'(irq0), 32'h0);
        mask = 8'h01;
        step(); step();
        chk("t4_irq", 32'(irq0), 32'h1);
        chk("t4_id", 32'(id0), 32'h0);
        cleanup();

        // request is never withdrawn
        mask = 8'hFF; set = 8'h02;
        step();
        set = 8'h00;
        step();
        clr = 8'h02; mask = 8'h00;
        step(); step();
        chk("t5_hold", 32'(irq0), 32'h1);
        chk("t5_hold_id", 32'(id0), 32'h1);
        clr = 8'h00; ack = 1'b1;
        step();
        ack = 1'b0;
        set = 8'h04;
        step();
        set = 8'h00; ack = 1'b1;
        step(); step();
        ack = 1'b0;
        chk("t5_idle_ack", 32'(q0), 32'h04);
        cleanup();

        // held-high set across an ack
        mask = 8'h01; set = 8'h01;
        step(); step(); step();
        ack = 1'b1;
        step();
        ack = 1'b0;
`ifdef SRQ_EDGE_DETECT_EN
        chk("t6_q_after_ack", 32'(q0[0]), 32'h0);
        step();
        chk("t6_no_reraise", 32'(irq0), 32'h0);
`else
        chk("t6_q_after_ack", 32'(q0[0]), 32'h1);
        step();
        chk("t6_reraise", 32'(irq0), 32'h1);
`endif
        step();
        cleanup();

        // reset in the middle of a request
        mask = 8'hFF; set = 8'h80;
        step();
        set = 8'h00;
        step();
        reset = 1'b1; set = 8'h01;
        step();
        chk("t7_rst_irq", 32'(irq0), 32'h0);
        chk("t7_rst_q", 32'(q0), 32'h0);
        reset = 1'b0; set = 8'h00;
        step(); step();

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            set   = 8'($urandom) & 8'($urandom) & 8'($urandom);
            clr   = 8'($urandom) & 8'($urandom) & 8'($urandom);
            mask  = 8'($urandom);
            ack   = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
